// File: rtl/sym_upsampler_4ask.sv
// Gray-coded 4-ASK mapper with 4x zero-stuffing upsampler.
// A small symbol FIFO decouples the symbol and sample enable phases.
module sym_upsampler_4ask #(
   parameter logic signed [17:0] LEVEL_A     = 18'sd32768,
   parameter int                 FIFO_DEPTH  = 4,
   parameter int                 PRIME_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sym_en,
   input  logic [1:0]         sym_in,
   input  logic               samp_en,
   output logic signed [17:0] sample_out,
   output logic               sample_valid,
   output logic [1:0]         sym_phase,
   output logic               running,
   output logic               underflow,
   output logic               overflow
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]   PRIME_C  = CNT_W'(PRIME_DEPTH);
   localparam logic signed [17:0] LEVEL_3A = LEVEL_A + (LEVEL_A <<< 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   function automatic logic signed [17:0] gray_level(input logic [1:0] sym);
      logic signed [17:0] lvl;
      case (sym)
         2'b00:   lvl = -LEVEL_3A;
         2'b01:   lvl = -LEVEL_A;
         2'b11:   lvl = LEVEL_A;
         2'b10:   lvl = LEVEL_3A;
         default: lvl = 18'sd0;
      endcase
      return lvl;
   endfunction

   logic [1:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [1:0]       phase_r;
   state_t           state_r;
   state_t           state_nxt_s;
   logic             go_run_s;
   logic             active_s;
   logic             rd_req_s;
   logic             pop_s;
   logic             push_s;
   logic             full_s;
   logic             empty_s;

   // Next-state logic: leave IDLE once primed at a sample enable
   always_comb begin
      state_nxt_s = state_r;
      go_run_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (samp_en && (count_r >= PRIME_C)) begin
               go_run_s    = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN:  state_nxt_s = ST_RUN;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FIFO handshake; an empty read never bypasses a same-cycle write
   always_comb begin
      full_s   = (count_r == DEPTH_C);
      empty_s  = (count_r == {CNT_W{1'b0}});
      active_s = samp_en && ((state_r == ST_RUN) || go_run_s);
      rd_req_s = active_s && (phase_r == 2'd0);
      pop_s    = rd_req_s && !empty_s;
      push_s   = sym_en && (!full_s || pop_s);
   end

   // Symbol storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= sym_in;
      end
   end

   // FIFO pointers and fill level
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // State, phase counter, registered outputs and sticky flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         phase_r      <= 2'd0;
         sample_out   <= 18'sd0;
         sample_valid <= 1'b0;
         sym_phase    <= 2'd0;
         running      <= 1'b0;
         underflow    <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         sample_valid <= samp_en;
         running      <= (state_nxt_s == ST_RUN);
         if (active_s) begin
            phase_r <= phase_r + 2'd1;
         end
         if (samp_en) begin
            sym_phase  <= active_s ? phase_r : 2'd0;
            sample_out <= pop_s ? gray_level(mem_r[rd_ptr_r]) : 18'sd0;
         end
         if (rd_req_s && empty_s) begin
            underflow <= 1'b1;
         end
         if (sym_en && full_s && !pop_s) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: doc/sym_upsampler_4ask.md
# sym_upsampler_4ask

Maps the 2-bit symbol stream from the 22-bit maximal-length LFSR into Gray-coded 4-ASK amplitude levels and upsamples by 4 with zero-stuffing, producing an 18-bit signed (1s17) sample stream for the downstream pulse-shaping filter. Runs on the system clock, qualified by the symbol-rate and sample-rate enables from `clk_gen`. A small FIFO absorbs the phase offset between the symbol and sample enables; underflow and overflow are flagged, not hidden.

## Interface

- `LEVEL_A`, 18'sd32768, inner amplitude A in 1s17 (0.25); outer level is 3A.
- `FIFO_DEPTH`, 4, symbol FIFO entries; power of two, 2..16.
- `PRIME_DEPTH`, 2, FIFO fill needed before the output starts; 1..FIFO_DEPTH.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `sym_en`  in  1  symbol-rate enable, one-cycle pulse; qualifies `sym_in`.
- `sym_in`  in  2  symbol from LFSR.
- `samp_en`  in  1  sample-rate enable (4x symbol rate), one-cycle pulse.
- `sample_out`  out  18  signed 1s17 upsampled sample.
- `sample_valid`  out  1  one-cycle pulse; `sample_out` updated this cycle.
- `sym_phase`  out  2  upsampling phase of the current `sample_out` (0 = symbol sample).
- `running`  out  1  high in RUN state.
- `underflow`  out  1  sticky; FIFO empty at a phase-0 read in RUN.
- `overflow`  out  1  sticky; write attempted to full FIFO without a simultaneous read.

## Operation

- Reset (`reset`=0 at a clock edge): FIFO emptied, state IDLE, `sample_out`=0, `sample_valid`=0, `sym_phase`=0, `running`=0, `underflow`=0, `overflow`=0.
- FIFO write: on `sym_en`, push `sym_in` unless full. Full and no read same cycle: drop symbol, set `overflow`. Full with read same cycle: push accepted, fill unchanged.
- FIFO read: only at `samp_en` in RUN with phase counter = 0. Empty FIFO: no bypass of a same-cycle write; counts as underflow.
- Mapping (Gray): 00 -> -3A, 01 -> -A, 11 -> +A, 10 -> +3A. 3A computed as `LEVEL_A` + (`LEVEL_A` <<< 1) at full 18-bit width; `LEVEL_A` <= 43690 so no overflow.
- State machine:
  - IDLE: phase counter held 0; on each `samp_en`, emit `sample_out`=0 with `sample_valid`. Go to RUN when fill >= `PRIME_DEPTH` at a `samp_en` cycle; that same `samp_en` is the first RUN phase-0 read.
  - RUN: on each `samp_en`, phase 0 pops one symbol and emits its level; phases 1..3 emit 0. Phase counter increments mod 4 on `samp_en`. Underflow at phase 0: emit 0, set `underflow`, remain in RUN, phase still advances.
  - Only reset returns to IDLE.
- Sticky flags clear only on reset.

## Timing

- `samp_en` at edge t -> `sample_out`, `sym_phase`, `sample_valid` registered, visible after edge t+1 (latency 1 cycle); `sample_valid` high exactly one cycle per `samp_en`.
- `sample_out` holds its value between `samp_en` pulses.
- `sym_en` at edge t -> fill increments after edge t; earliest pop at a `samp_en` one cycle later.
- `running` rises the cycle the first RUN sample is presented.
- `sym_en` and `samp_en` coincident: write and read both act in the same cycle.
- Reset asserted mid-stream: outputs at reset values on the next cycle regardless of enables; enables during reset ignored.

## Test plan

- Reset, then 4 `sym_en` with 00,01,11,10 at 1/16 clk, `samp_en` at 1/4 clk -> after priming, sample sequence -98304,0,0,0,-32768,0,0,0,32768,0,0,0,98304,0,0,0; `sym_phase` 0,1,2,3 repeating.
- Drive from `clk_gen` enables and `lfsr_22_max` symbols for 10k symbols -> no `underflow`/`overflow`; every phase-0 sample matches the Gray map of the symbol stream delayed through the FIFO; phases 1..3 always 0.
- `samp_en` only, no `sym_en` -> stays IDLE, `running`=0, samples all 0, `underflow` stays 0.
- Prime, then stop `sym_en` -> at first empty phase-0 read, sample 0 and `underflow`=1 (sticky), phase continues 1,2,3.
- Stop `samp_en`, issue 5 `sym_en` -> 4 stored, 5th dropped, `overflow`=1; coincident `sym_en`+phase-0 `samp_en` on a full FIFO -> no `overflow`.
- Assert `reset` mid-RUN for one cycle -> next cycle all outputs 0, flags cleared, state IDLE, re-priming required.
